// File: rtl/trace_cmd_dispatcher_pkg.sv
// Shared types for the trace command dispatcher: command codes, channel op encodings,
// the trace record layout and the head-routing helpers.
package trace_pkg;

    localparam int unsigned CMD_DR    = 0;
    localparam int unsigned CMD_DW    = 1;
    localparam int unsigned CMD_IR    = 2;
    localparam int unsigned CMD_SNP_I = 3;
    localparam int unsigned CMD_SNP_R = 4;
    localparam int unsigned CMD_SNP_W = 5;
    localparam int unsigned CMD_SNP_M = 6;
    localparam int unsigned CMD_CLEAR = 8;
    localparam int unsigned CMD_PRINT = 9;

    localparam int unsigned NUM_STATS    = 11;
    localparam int unsigned STAT_BAD_IDX = 10;

    typedef enum logic [1:0] {
        L1OpDr = 2'd0,
        L1OpDw = 2'd1,
        L1OpIr = 2'd2
    } l1_op_e;

    typedef enum logic [1:0] {
        SnpOpI = 2'd0,
        SnpOpR = 2'd1,
        SnpOpW = 2'd2,
        SnpOpM = 2'd3
    } snp_op_e;

    typedef enum logic [2:0] {
        RouteL1,
        RouteSnp,
        RouteClear,
        RoutePrint,
        RouteBad
    } route_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } trace_rec_t;

    function automatic route_e classify(input int unsigned cmd);
        if (cmd <= CMD_IR) begin
            return RouteL1;
        end else if (cmd <= CMD_SNP_M) begin
            return RouteSnp;
        end else if (cmd == CMD_CLEAR) begin
            return RouteClear;
        end else if (cmd == CMD_PRINT) begin
            return RoutePrint;
        end
        return RouteBad;
    endfunction

    function automatic l1_op_e to_l1_op(input int unsigned cmd);
        return l1_op_e'(2'(cmd));
    endfunction

    function automatic snp_op_e to_snp_op(input int unsigned cmd);
        return snp_op_e'(2'(cmd - CMD_SNP_I));
    endfunction

endpackage

// File: rtl/trace_cmd_dispatcher_if.sv
// Trace dispatcher channel bundle: record input, L1 request, snoop request and
// control pulses. The slave modport is the dispatcher's view.
interface trace_cmd_dispatcher_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CMD_W  = 4
);

    logic              in_valid;
    logic              in_ready;
    logic [CMD_W-1:0]  in_cmd;
    logic [ADDR_W-1:0] in_addr;

    logic              l1_valid;
    logic              l1_ready;
    logic [1:0]        l1_op;
    logic [ADDR_W-1:0] l1_addr;

    logic              snp_valid;
    logic              snp_ready;
    logic [1:0]        snp_op;
    logic [ADDR_W-1:0] snp_addr;

    logic              clear_pulse;
    logic              print_pulse;
    logic              bad_cmd_pulse;

    modport master (
        output in_valid, in_cmd, in_addr, l1_ready, snp_ready,
        input  in_ready, l1_valid, l1_op, l1_addr, snp_valid, snp_op, snp_addr,
        input  clear_pulse, print_pulse, bad_cmd_pulse
    );

    modport slave (
        input  in_valid, in_cmd, in_addr, l1_ready, snp_ready,
        output in_ready, l1_valid, l1_op, l1_addr, snp_valid, snp_op, snp_addr,
        output clear_pulse, print_pulse, bad_cmd_pulse
    );

endinterface

// File: rtl/trace_cmd_dispatcher_fifo.sv
// trace_fifo: synchronous circular-buffer FIFO with wrapping pointers and a separate
// occupancy count. Depth must be a power of two, at least 2.
module trace_fifo
    import trace_pkg::*;
#(
    parameter type         T     = trace_rec_t,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/trace_cmd_dispatcher.sv
// Buffers trace records and dispatches them in order to the L1, snoop or pulse outputs.
// Optional per-command statistics counters are built when TRACE_STATS_EN is defined.
module trace_cmd_dispatcher
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CMD_W  = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    trace_cmd_dispatcher_if.slave        bus,
    input  logic [3:0]                   stat_sel,
    output logic [CNT_W-1:0]             stat_value
);

    localparam int unsigned CountW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
    } rec_t;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StStall
    } state_e;

    rec_t              fifo_wdata;
    rec_t              head;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CountW-1:0] fifo_count;
    logic              empty_next;
    int unsigned       head_cmd;
    route_e            route;
    logic              l1_free;
    logic              snp_free;

    state_e            state_q,     state_d;
    logic              l1_valid_q,  l1_valid_d;
    l1_op_e            l1_op_q,     l1_op_d;
    logic [ADDR_W-1:0] l1_addr_q,   l1_addr_d;
    logic              snp_valid_q, snp_valid_d;
    snp_op_e           snp_op_q,    snp_op_d;
    logic [ADDR_W-1:0] snp_addr_q,  snp_addr_d;
    logic              clear_q,     clear_d;
    logic              print_q,     print_d;
    logic              bad_q,       bad_d;

    assign fifo_wdata.cmd  = bus.in_cmd;
    assign fifo_wdata.addr = bus.in_addr;
    assign bus.in_ready    = !fifo_full;
    assign push            = bus.in_valid && !fifo_full;

    trace_fifo #(
        .T     (rec_t),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_cmd = 32'(head.cmd);
    assign route    = classify(head_cmd);
    assign l1_free  = !l1_valid_q || bus.l1_ready;
    assign snp_free = !snp_valid_q || bus.snp_ready;

    always_comb begin
        pop         = 1'b0;
        state_d     = state_q;
        l1_valid_d  = l1_valid_q && !bus.l1_ready;
        l1_op_d     = l1_op_q;
        l1_addr_d   = l1_addr_q;
        snp_valid_d = snp_valid_q && !bus.snp_ready;
        snp_op_d    = snp_op_q;
        snp_addr_d  = snp_addr_q;
        clear_d     = 1'b0;
        print_d     = 1'b0;
        bad_d       = 1'b0;

        case (state_q)
            StDispatch, StStall: begin
                if (!fifo_empty) begin
                    case (route)
                        RouteL1: begin
                            if (l1_free) begin
                                pop        = 1'b1;
                                l1_valid_d = 1'b1;
                                l1_op_d    = to_l1_op(head_cmd);
                                l1_addr_d  = head.addr;
                            end
                        end
                        RouteSnp: begin
                            if (snp_free) begin
                                pop         = 1'b1;
                                snp_valid_d = 1'b1;
                                snp_op_d    = to_snp_op(head_cmd);
                                snp_addr_d  = head.addr;
                            end
                        end
                        RouteClear: begin
                            pop     = 1'b1;
                            clear_d = 1'b1;
                        end
                        RoutePrint: begin
                            pop     = 1'b1;
                            print_d = 1'b1;
                        end
                        default: begin
                            pop   = 1'b1;
                            bad_d = 1'b1;
                        end
                    endcase
                end
            end
            default: ;
        endcase

        // StIdle is entered exactly when the FIFO will be empty next cycle.
        empty_next = ((fifo_count == '0) && !push) ||
                     ((fifo_count == CountW'(1)) && pop && !push);
        if (empty_next) begin
            state_d = StIdle;
        end else if ((state_q != StIdle) && !pop) begin
            state_d = StStall;
        end else begin
            state_d = StDispatch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            l1_valid_q  <= 1'b0;
            l1_op_q     <= L1OpDr;
            l1_addr_q   <= '0;
            snp_valid_q <= 1'b0;
            snp_op_q    <= SnpOpI;
            snp_addr_q  <= '0;
            clear_q     <= 1'b0;
            print_q     <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            l1_valid_q  <= l1_valid_d;
            l1_op_q     <= l1_op_d;
            l1_addr_q   <= l1_addr_d;
            snp_valid_q <= snp_valid_d;
            snp_op_q    <= snp_op_d;
            snp_addr_q  <= snp_addr_d;
            clear_q     <= clear_d;
            print_q     <= print_d;
            bad_q       <= bad_d;
        end
    end

    assign bus.l1_valid      = l1_valid_q;
    assign bus.l1_op         = l1_op_q;
    assign bus.l1_addr       = l1_addr_q;
    assign bus.snp_valid     = snp_valid_q;
    assign bus.snp_op        = snp_op_q;
    assign bus.snp_addr      = snp_addr_q;
    assign bus.clear_pulse   = clear_q;
    assign bus.print_pulse   = print_q;
    assign bus.bad_cmd_pulse = bad_q;

`ifdef TRACE_STATS_EN
    logic [CNT_W-1:0] stat_q [NUM_STATS];
    logic [3:0]       stat_idx;

    assign stat_idx = (route == RouteBad) ? 4'(STAT_BAD_IDX) : 4'(head_cmd);

    // Counters saturate and survive the clear command; only reset zeroes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_q[i] <= '0;
            end
        end else if (pop && (stat_q[stat_idx] != '1)) begin
            stat_q[stat_idx] <= stat_q[stat_idx] + CNT_W'(1);
        end
    end

    always_comb begin
        stat_value = '0;
        if (stat_sel <= 4'(STAT_BAD_IDX)) begin
            stat_value = stat_q[stat_sel];
        end
    end
`else
    logic unused_stat_sel;

    assign unused_stat_sel = ^stat_sel;
    assign stat_value      = '0;
`endif

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// Directed bench for trace_cmd_dispatcher: vector table plus hand-written stall,
// pulse, streaming, reset and statistics sequences, with an in-order scoreboard.
module tb_trace_cmd_dispatcher;

    localparam int unsigned CntW = 2;
`ifdef TRACE_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      stat_sel;
    logic [CntW-1:0] stat_value;

    always #5 clk = ~clk;

    trace_cmd_dispatcher_if #(.ADDR_W(32), .CMD_W(4)) bus ();

    trace_cmd_dispatcher #(
        .ADDR_W (32),
        .CMD_W  (4),
        .DEPTH  (8),
        .CNT_W  (CntW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .stat_sel   (stat_sel),
        .stat_value (stat_value)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
    } exp_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        l1v;
        logic [1:0]  l1op;
        logic        snpv;
        logic [1:0]  snpop;
        logic [2:0]  pulses;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_l1[$];
    exp_t exp_snp[$];
    int   exp_pulse[$];
    exp_t mon_e;
    int   mon_k;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_rec(input logic [3:0] cmd, input logic [31:0] addr);
        exp_t e;
        e.addr = addr;
        e.op   = 2'd0;
        if (cmd <= 4'd2) begin
            e.op = cmd[1:0];
            exp_l1.push_back(e);
        end else if (cmd <= 4'd6) begin
            e.op = 2'(cmd - 4'd3);
            exp_snp.push_back(e);
        end else if (cmd == 4'd8) begin
            exp_pulse.push_back(0);
        end else if (cmd == 4'd9) begin
            exp_pulse.push_back(1);
        end else begin
            exp_pulse.push_back(2);
        end
    endfunction

    task automatic push(input logic [3:0] cmd, input logic [31:0] addr);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_addr  = addr;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.in_ready) done = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (done) begin
            expect_rec(cmd, addr);
        end else begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for 100 cycles, want 1");
        end
    endtask

    // Scoreboard: every accepted request or pulse must match the next expected one.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.l1_valid && bus.l1_ready) begin
                if (exp_l1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL l1_unexpected: got addr 0x%0h, want none", bus.l1_addr);
                end else begin
                    mon_e = exp_l1.pop_front();
                    chk("l1_order_op", 64'(bus.l1_op), 64'(mon_e.op));
                    chk("l1_order_addr", 64'(bus.l1_addr), 64'(mon_e.addr));
                end
            end
            if (bus.snp_valid && bus.snp_ready) begin
                if (exp_snp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL snp_unexpected: got addr 0x%0h, want none", bus.snp_addr);
                end else begin
                    mon_e = exp_snp.pop_front();
                    chk("snp_order_op", 64'(bus.snp_op), 64'(mon_e.op));
                    chk("snp_order_addr", 64'(bus.snp_addr), 64'(mon_e.addr));
                end
            end
            if (bus.clear_pulse || bus.print_pulse || bus.bad_cmd_pulse) begin
                mon_k = bus.clear_pulse ? 0 : (bus.print_pulse ? 1 : 2);
                if (exp_pulse.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_unexpected: got kind %0d, want none", mon_k);
                end else begin
                    chk("pulse_order",
                        64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}),
                        64'(3'b100 >> exp_pulse.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'd0,  32'h1000, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000};
        vecs[1]  = '{4'd1,  32'h1004, 1'b1, 2'd1, 1'b0, 2'd0, 3'b000};
        vecs[2]  = '{4'd2,  32'h1008, 1'b1, 2'd2, 1'b0, 2'd0, 3'b000};
        vecs[3]  = '{4'd3,  32'h2000, 1'b0, 2'd0, 1'b1, 2'd0, 3'b000};
        vecs[4]  = '{4'd4,  32'h2004, 1'b0, 2'd0, 1'b1, 2'd1, 3'b000};
        vecs[5]  = '{4'd5,  32'h2008, 1'b0, 2'd0, 1'b1, 2'd2, 3'b000};
        vecs[6]  = '{4'd6,  32'h200c, 1'b0, 2'd0, 1'b1, 2'd3, 3'b000};
        vecs[7]  = '{4'd7,  32'h3000, 1'b0, 2'd0, 1'b0, 2'd0, 3'b001};
        vecs[8]  = '{4'd8,  32'h3004, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100};
        vecs[9]  = '{4'd9,  32'h3008, 1'b0, 2'd0, 1'b0, 2'd0, 3'b010};
        vecs[10] = '{4'd10, 32'h300c, 1'b0, 2'd0, 1'b0, 2'd0, 3'b001};
        vecs[11] = '{4'd15, 32'h3010, 1'b0, 2'd0, 1'b0, 2'd0, 3'b001};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_cmd    = 4'd0;
        bus.in_addr   = 32'h0;
        bus.l1_ready  = 1'b1;
        bus.snp_ready = 1'b1;
        stat_sel      = 4'd0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_l1_valid", 64'(bus.l1_valid), 64'(0));
        chk("rst_snp_valid", 64'(bus.snp_valid), 64'(0));
        chk("rst_pulses", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}), 64'(0));
        chk("rst_ops", 64'({bus.l1_op, bus.snp_op}), 64'(0));
        chk("rst_addrs", {bus.l1_addr, bus.snp_addr}, 64'(0));

        // First record: nothing the cycle after the push, valid the cycle after that.
        push(4'd0, 32'h1000);
        chk("first_early", 64'(bus.l1_valid), 64'(0));
        tick();
        chk("first_l1_valid", 64'(bus.l1_valid), 64'(1));
        chk("first_l1_op", 64'(bus.l1_op), 64'(0));
        chk("first_l1_addr", 64'(bus.l1_addr), 64'h1000);
        chk("first_snp_idle", 64'(bus.snp_valid), 64'(0));
        tick();

        for (int i = 0; i < 12; i++) begin
            push(vecs[i].cmd, vecs[i].addr);
            chk("tbl_early", 64'({bus.l1_valid, bus.snp_valid, bus.clear_pulse,
                                 bus.print_pulse, bus.bad_cmd_pulse}), 64'(0));
            tick();
            chk("tbl_l1_valid", 64'(bus.l1_valid), 64'(vecs[i].l1v));
            chk("tbl_snp_valid", 64'(bus.snp_valid), 64'(vecs[i].snpv));
            chk("tbl_pulses", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}),
                64'(vecs[i].pulses));
            if (vecs[i].l1v) begin
                chk("tbl_l1_op", 64'(bus.l1_op), 64'(vecs[i].l1op));
                chk("tbl_l1_addr", 64'(bus.l1_addr), 64'(vecs[i].addr));
            end
            if (vecs[i].snpv) begin
                chk("tbl_snp_op", 64'(bus.snp_op), 64'(vecs[i].snpop));
                chk("tbl_snp_addr", 64'(bus.snp_addr), 64'(vecs[i].addr));
            end
            tick();
        end

        // L1 stall blocks the snoop records queued behind it.
        bus.l1_ready = 1'b0;
        push(4'd1, 32'h10);
        push(4'd1, 32'h20);
        push(4'd1, 32'h30);
        for (int i = 0; i < 6; i++) push(4'd4, 32'h100 + 32'(i));
        chk("stall_full", 64'(bus.in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            chk("stall_no_snp", 64'(bus.snp_valid), 64'(0));
            chk("stall_l1_hold", 64'({bus.l1_valid, bus.l1_op, bus.l1_addr}),
                64'({1'b1, 2'd1, 32'h10}));
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            tick();
        end
        bus.l1_ready = 1'b1;
        for (int i = 6; i < 9; i++) push(4'd4, 32'h100 + 32'(i));
        for (int i = 0; i < 50 && (exp_l1.size() + exp_snp.size()) != 0; i++) tick();
        chk("stall_drain", 64'(exp_l1.size() + exp_snp.size()), 64'(0));
        tick();

        // Back-to-back pulse commands.
        chk("pulse_ready", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_cmd   = 4'd8;
        expect_rec(4'd8, 32'h0);
        tick();
        chk("pulse_c0", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}), 64'(0));
        bus.in_cmd = 4'd9;
        expect_rec(4'd9, 32'h0);
        tick();
        chk("pulse_c1", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}), 64'(4));
        bus.in_cmd = 4'd7;
        expect_rec(4'd7, 32'h0);
        tick();
        chk("pulse_c2", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}), 64'(2));
        bus.in_valid = 1'b0;
        tick();
        chk("pulse_c3", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}), 64'(1));
        tick();
        chk("pulse_c4", 64'({bus.clear_pulse, bus.print_pulse, bus.bad_cmd_pulse}), 64'(0));

        // Full-rate stream: one acceptance per cycle per channel.
        for (int i = 0; i < 20; i++) begin
            chk("stream_ready", 64'(bus.in_ready), 64'(1));
            bus.in_valid = 1'b1;
            bus.in_cmd   = (i < 10) ? 4'(i % 3) : 4'(3 + i % 4);
            bus.in_addr  = 32'h2000 + 32'(4 * i);
            expect_rec(bus.in_cmd, bus.in_addr);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("stream_l1_left", 64'(exp_l1.size()), 64'(0));
        chk("stream_snp_left", 64'(exp_snp.size()), 64'(0));

        // Reset with records queued and an L1 request pending.
        bus.l1_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(4'd0, 32'h4000 + 32'(i));
        chk("mid_l1_valid", 64'(bus.l1_valid), 64'(1));
        reset = 1'b1;
        exp_l1.delete();
        exp_snp.delete();
        exp_pulse.delete();
        tick();
        chk("mid_rst_valids", 64'({bus.l1_valid, bus.snp_valid}), 64'(0));
        chk("mid_rst_count", 64'(dut.fifo_count), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("mid_rst_l1_addr", 64'(bus.l1_addr), 64'(0));
        reset        = 1'b0;
        bus.l1_ready = 1'b1;
        repeat (8) tick();
        chk("mid_no_emerge", 64'({bus.l1_valid, bus.snp_valid}), 64'(0));

        // Statistics, 2-bit counters: three cmd-2 pops already hit all-ones.
        push(4'd2, 32'h5000);
        push(4'd2, 32'h5004);
        push(4'd2, 32'h5008);
        push(4'd12, 32'h500c);
        repeat (3) tick();
        stat_sel = 4'd2;
        #1;
        chk("stat_cmd2", 64'(stat_value), StatsEn ? 64'(3) : 64'(0));
        stat_sel = 4'd10;
        #1;
        chk("stat_bad", 64'(stat_value), StatsEn ? 64'(1) : 64'(0));
        stat_sel = 4'd12;
        #1;
        chk("stat_sel12", 64'(stat_value), 64'(0));
        push(4'd8, 32'h0);
        push(4'd2, 32'h5010);
        repeat (3) tick();
        stat_sel = 4'd2;
        #1;
        chk("stat_saturate", 64'(stat_value), StatsEn ? 64'(3) : 64'(0));
        stat_sel = 4'd8;
        #1;
        chk("stat_clear_cnt", 64'(stat_value), StatsEn ? 64'(1) : 64'(0));

        chk("end_queues", 64'(exp_l1.size() + exp_snp.size() + exp_pulse.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
